// File: rtl/source_gen_mc.sv
// source_gen_mc: multi-channel write-stimulus source.
// Issues per-channel write addresses and a registered write strobe into a
// downstream buffer for one frame of NUM_CH*len samples. The channel order is
// either interleaved or sequential per channel. Generation throttles on the
// buffer's almost-full flag and can be aborted with stop.
module source_gen_mc #(
  parameter int ADDR_WIDTH = 7,
  parameter int NUM_CH     = 4,
  parameter int CH_WIDTH   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         en,
  input  logic                         mode,
  input  logic [ADDR_WIDTH-1:0]        len,
  input  logic                         Afull,
  output logic                         WE,
  output logic [ADDR_WIDTH-1:0]        addr,
  output logic [CH_WIDTH-1:0]          ch_id,
  output logic                         busy,
  output logic                         done,
  output logic [ADDR_WIDTH+CH_WIDTH-1:0] wr_count
);

  localparam int WCW = ADDR_WIDTH + CH_WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state_reg, state_next;
  logic                  we_reg, we_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [CH_WIDTH-1:0]   ch_id_reg, ch_id_next;
  logic [CH_WIDTH-1:0]   ch_reg, ch_next;
  logic [WCW-1:0]        wr_count_reg, wr_count_next;
  logic [ADDR_WIDTH-1:0] len_reg, len_next;
  logic                  mode_reg, mode_next;
  logic [ADDR_WIDTH-1:0] cnt_reg [NUM_CH];

  logic                  clr_cnt;
  logic                  wr_fire;
  logic [ADDR_WIDTH-1:0] cur_cnt;
  logic [WCW:0]          frame_total;
  logic                  last_wr;
  logic                  ch_last_sample;

  assign cur_cnt        = cnt_reg[ch_reg];
  assign frame_total    = (WCW+1)'(NUM_CH) * (WCW+1)'(len_reg);
  assign last_wr        = ({1'b0, wr_count_reg} + (WCW+1)'(1)) == frame_total;
  assign ch_last_sample = (cur_cnt + ADDR_WIDTH'(1)) == len_reg;

  // Per-channel sample counters: cleared on frame start, bumped on a write to that channel.
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_cnt
      always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
          cnt_reg[gi] <= '0;
        end else if (wr_fire && (ch_reg == CH_WIDTH'(gi))) begin
          cnt_reg[gi] <= cnt_reg[gi] + ADDR_WIDTH'(1);
        end
      end
    end
  endgenerate

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      we_reg       <= 1'b0;
      addr_reg     <= '0;
      ch_id_reg    <= '0;
      ch_reg       <= '0;
      wr_count_reg <= '0;
      len_reg      <= '0;
      mode_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      we_reg       <= we_next;
      addr_reg     <= addr_next;
      ch_id_reg    <= ch_id_next;
      ch_reg       <= ch_next;
      wr_count_reg <= wr_count_next;
      len_reg      <= len_next;
      mode_reg     <= mode_next;
    end
  end

  // Next-state and write generation; stop overrides everything, including a write.
  always_comb begin
    state_next    = state_reg;
    we_next       = 1'b0;
    addr_next     = addr_reg;
    ch_id_next    = ch_id_reg;
    ch_next       = ch_reg;
    wr_count_next = wr_count_reg;
    len_next      = len_reg;
    mode_next     = mode_reg;
    clr_cnt       = 1'b0;
    wr_fire       = 1'b0;
    if (stop) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            len_next      = len;
            mode_next     = mode;
            clr_cnt       = 1'b1;
            ch_next       = '0;
            wr_count_next = '0;
            state_next    = (len == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (en && !Afull) begin
            wr_fire       = 1'b1;
            we_next       = 1'b1;
            addr_next     = cur_cnt;
            ch_id_next    = ch_reg;
            wr_count_next = wr_count_reg + WCW'(1);
            // Interleaved mode moves on after every write; sequential mode
            // only after the channel's final sample of the frame.
            if (!mode_reg || ch_last_sample) begin
              ch_next = (ch_reg == CH_WIDTH'(NUM_CH-1)) ? '0 : ch_reg + CH_WIDTH'(1);
            end
            if (last_wr) begin
              state_next = DONE;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign WE       = we_reg;
  assign addr     = addr_reg;
  assign ch_id    = ch_id_reg;
  assign wr_count = wr_count_reg;
  assign busy     = (state_reg == RUN);
  // The final write's strobe is still high on the first DONE cycle; done is
  // held off until it has fallen.
  assign done     = (state_reg == DONE) && !we_reg;

endmodule

// File: tb/tb_source_gen_mc.sv
// tb_source_gen_mc: directed bench for source_gen_mc with an expected-write scoreboard.
module tb_source_gen_mc;

  localparam int AW  = 7;
  localparam int NCH = 4;
  localparam int CW  = 2;

  logic          clk = 1'b0;
  logic          rst, start, stop, en, mode, Afull;
  logic [AW-1:0] len;
  logic          WE, busy, done;
  logic [AW-1:0] addr;
  logic [CW-1:0] ch_id;
  logic [AW+CW-1:0] wr_count;

  typedef struct {
    int ch;
    int addr;
  } exp_t;

  exp_t q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   n_we     = 0;
  logic cur_we   = 1'b0;
  logic prev_we  = 1'b0;
  int   cyc;

  source_gen_mc #(.ADDR_WIDTH(AW), .NUM_CH(NCH)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .en(en), .mode(mode),
    .len(len), .Afull(Afull), .WE(WE), .addr(addr), .ch_id(ch_id),
    .busy(busy), .done(done), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected (ch,addr) sequence for a full frame.
  task automatic push_frame(input int l, input int m);
    exp_t e;
    if (m == 0) begin
      for (int a = 0; a < l; a++)
        for (int c = 0; c < NCH; c++) begin
          e.ch = c; e.addr = a; q.push_back(e);
        end
    end else begin
      for (int c = 0; c < NCH; c++)
        for (int a = 0; a < l; a++) begin
          e.ch = c; e.addr = a; q.push_back(e);
        end
    end
  endtask

  // Advance one clock, sample just after the edge, score any write.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    prev_we = cur_we;
    cur_we  = WE;
    if (WE === 1'b1) begin
      n_we++;
      if (q.size() == 0) begin
        check("we_unexpected", WE, 0);
      end else begin
        e = q.pop_front();
        $display("write %0d: ch_id=%0d addr=%0d (exp ch=%0d addr=%0d)", n_we, ch_id, addr, e.ch, e.addr);
        check("ch_id", ch_id, e.ch);
        check("addr", addr, e.addr);
      end
    end
  endtask

  task automatic run_until_done(input int budget, output int c);
    c = 0;
    do begin
      step();
      c++;
    end while (done !== 1'b1 && c < budget);
    check("done_reached", done, 1);
    check("we_low_at_done", cur_we, 0);
    check("busy_low_at_done", busy, 0);
  endtask

  task automatic start_frame(input int l, input int m);
    len = AW'(l); mode = m[0]; start = 1'b1;
    n_we = 0;
    step();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; en = 1'b0; mode = 1'b0; Afull = 1'b0; len = '0;
    step();
    step();
    check("rst_we", WE, 0);
    check("rst_addr", addr, 0);
    check("rst_ch_id", ch_id, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wr_count", wr_count, 0);
    rst = 1'b0;
    en  = 1'b1;
    step();

    // Interleaved frame, len=3: 12 back-to-back writes, done one cycle later.
    push_frame(3, 0);
    start_frame(3, 0);
    check("t1_busy", busy, 1);
    check("t1_we_latency", WE, 0);
    run_until_done(40, cyc);
    check("t1_cycles", cyc, 13);
    check("t1_prev_we", prev_we, 1);
    check("t1_n_we", n_we, 12);
    check("t1_wr_count", wr_count, 12);
    check("t1_sb_empty", q.size(), 0);

    // Sequential frame, len=3.
    push_frame(3, 1);
    start_frame(3, 1);
    run_until_done(40, cyc);
    check("t2_cycles", cyc, 13);
    check("t2_n_we", n_we, 12);
    check("t2_wr_count", wr_count, 12);
    check("t2_sb_empty", q.size(), 0);

    // Interleaved len=5 with Afull high for 3 cycles after the 2nd write.
    push_frame(5, 0);
    start_frame(5, 0);
    step();
    step();
    check("t3_n_we_before_afull", n_we, 2);
    Afull = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t3_we_afull", WE, 0);
    end
    Afull = 1'b0;
    run_until_done(60, cyc);
    check("t3_cycles", cyc, 19);
    check("t3_n_we", n_we, 20);
    check("t3_wr_count", wr_count, 20);
    check("t3_sb_empty", q.size(), 0);

    // Stop after the 6th write, then restart from ch0 addr0.
    push_frame(3, 0);
    start_frame(3, 0);
    for (int i = 0; i < 6; i++) step();
    check("t4_n_we", n_we, 6);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("t4_we_after_stop", WE, 0);
    check("t4_busy_after_stop", busy, 0);
    check("t4_done_after_stop", done, 0);
    check("t4_wr_count", wr_count, 6);
    step();
    check("t4_idle_we", WE, 0);
    q.delete();
    push_frame(3, 0);
    start_frame(3, 0);
    run_until_done(40, cyc);
    check("t4_restart_n_we", n_we, 12);
    check("t4_sb_empty", q.size(), 0);

    // len=0: straight to DONE, no writes.
    start_frame(0, 0);
    check("t5_done", done, 1);
    check("t5_busy", busy, 0);
    check("t5_we", WE, 0);
    check("t5_wr_count", wr_count, 0);
    step();
    step();
    check("t5_n_we", n_we, 0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("t5_done_cleared", done, 0);
    // start and stop together from IDLE: stays IDLE.
    start = 1'b1; stop = 1'b1; len = AW'(3);
    step();
    start = 1'b0; stop = 1'b0;
    check("t5_ss_busy", busy, 0);
    check("t5_ss_done", done, 0);
    step();
    check("t5_ss_we", WE, 0);

    // en low for 4 cycles mid-frame freezes generation.
    push_frame(3, 0);
    start_frame(3, 0);
    step();
    step();
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t6_we_en_low", WE, 0);
      check("t6_wr_count_frozen", wr_count, 2);
    end
    en = 1'b1;
    run_until_done(40, cyc);
    check("t6_cycles", cyc, 11);
    check("t6_n_we", n_we, 12);
    check("t6_sb_empty", q.size(), 0);

    // Reset mid-frame: all outputs zero, no further writes.
    push_frame(3, 0);
    start_frame(3, 0);
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    q.delete();
    check("t7_we", WE, 0);
    check("t7_addr", addr, 0);
    check("t7_ch_id", ch_id, 0);
    check("t7_busy", busy, 0);
    check("t7_done", done, 0);
    check("t7_wr_count", wr_count, 0);
    for (int i = 0; i < 4; i++) step();
    check("t7_n_we", n_we, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/source_gen_mc.md
Name: source_gen_mc

Overview:
Parametrised multi-channel write-stimulus source, the next generation of the single-channel simulation source. It generates per-channel write addresses and a write strobe into a downstream buffer, and throttles on the buffer's almost-full flag. It adds a frame length, start/stop control, interleaved or sequential channel ordering, and a done flag. It sits in front of the sample FIFO/RAM in simulation benches and in self-test datapaths.

Parameters:
ADDR_WIDTH, 7, width of each per-channel address counter and of len
NUM_CH, 4, number of channels (>=1)
CH_WIDTH, $clog2(NUM_CH) min 1, width of ch_id

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  single-cycle pulse that begins a frame
stop  in  1  single-cycle pulse that aborts the frame
en  in  1  global enable; low freezes generation
mode  in  1  0 = interleaved round-robin, 1 = sequential per channel
len  in  ADDR_WIDTH  samples per channel per frame, sampled on start
Afull  in  1  downstream almost-full; high blocks a write
WE  out  1  write strobe, registered
addr  out  ADDR_WIDTH  per-channel write address, registered
ch_id  out  CH_WIDTH  channel of current write, registered
busy  out  1  high in RUN
done  out  1  high in DONE, sticky
wr_count  out  ADDR_WIDTH+CH_WIDTH  total writes issued in current frame

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset: state=IDLE; WE=0, addr=0, ch_id=0, busy=0, done=0, wr_count=0; all per-channel counters=0; len register=0.
- States and transitions:
  - IDLE: start -> RUN.
  - RUN: last write issued -> DONE; stop -> IDLE.
  - DONE: start -> RUN.
  - start in RUN is ignored.
- On start accepted:
  - len_r<=len; all channel counters, ch pointer and wr_count clear to 0.
  - If len==0: go directly to DONE with no writes.
- Write condition each cycle in RUN: go = en & ~Afull (Afull and en sampled at that edge).
  - go=1 at edge k: WE=1, addr=cnt[ch], ch_id=ch after edge k.
  - Same edge: cnt[ch]++, wr_count++, pointer advances.
  - go=0: WE=0 after the edge; addr/ch_id hold their last values; counters hold.
  - Latency: start at edge k -> earliest WE high after edge k+1.
- Pointer advance:
  - mode 0: ch wraps NUM_CH-1 -> 0 after every write.
  - mode 1: ch stays until cnt[ch] reaches len_r-1 on this write, then ch+1.
  - mode is sampled on start and held for the frame.
- Last write: wr_count == NUM_CH*len_r-1 at a go edge. That edge issues the write and moves to DONE. WE falls the following cycle. done=1 from the cycle after the last WE; busy=0.
- stop:
  - Any state -> IDLE; WE=0 next cycle; done=0; counters hold their values (readable via wr_count).
  - stop and start in the same cycle: stop wins.
  - stop and a go in the same cycle: no write issued.
- Counter widths: len < 2^ADDR_WIDTH, so cnt never wraps within a frame. wr_count holds NUM_CH*(2^ADDR_WIDTH-1) without overflow.
- Afull is treated as almost-full. The sink must assert it with at least one entry of slack, because WE is registered one cycle after the sample.
- rst mid-frame: immediate return to reset values at the next edge. No partial write follows.

Test Plan:
- NUM_CH=4, mode=0, len=3, en=1, Afull=0, start pulse -> 12 consecutive WE cycles. ch_id 0,1,2,3,0,... and addr 0,0,0,0,1,1,1,1,2,2,2,2. done=1 one cycle after the last WE; wr_count=12.
- Same setup with mode=1 -> ch_id 0,0,0,1,1,1,2,2,2,3,3,3 and addr 0,1,2 repeated per channel; done after 12 writes.
- mode=0, len=5, Afull high for 3 cycles after the 2nd write -> WE low exactly 3 cycles. addr/ch_id resume at ch2 addr0 with no skipped or duplicated (ch,addr) pair; 20 writes total.
- stop asserted after the 6th write -> WE=0 the next cycle, state IDLE, done=0, wr_count=6. A new start restarts at ch0 addr0.
- len=0 start -> no WE, done=1 the next cycle. start+stop in the same cycle from IDLE -> stays IDLE.
- rst pulsed mid-frame with en=1 -> all outputs 0 the next cycle, no further WE. en=0 for 4 cycles -> WE low and counters frozen for those 4 cycles.
